// File: rtl/eq_pkg.sv
// Shared types and constants for the EQ gain stage.
package eq_pkg;

    localparam int unsigned DW   = 16;
    localparam int unsigned GW   = 8;
    localparam int unsigned FRAC = 7;
    localparam int unsigned PW   = DW + GW + 1;

    localparam int unsigned CTRL_MUTE   = 0;
    localparam int unsigned CTRL_BYPASS = 1;

    localparam logic [GW-1:0] UNITY_GAIN = 8'h80;

    typedef enum logic [2:0] {
        IDLE,
        ML1,
        ML2,
        MR1,
        MR2,
        OUT
    } state_t;

    typedef struct packed {
        logic [GW-1:0] gain_l;
        logic [GW-1:0] gain_r;
        logic [GW-1:0] master;
        logic [GW-1:0] ctrl;
    } eq_coef_t;

    localparam eq_coef_t COEF_RESET = '{
        gain_l: UNITY_GAIN,
        gain_r: UNITY_GAIN,
        master: UNITY_GAIN,
        ctrl:   '0
    };

endpackage

// File: rtl/eq_gain_stage_sat_mul.sv
// Single shared multiplier: operand mux, Q1.7 scale, floor shift, saturate.
module eq_sat_mul
    import eq_pkg::*;
(
    input  state_t               state,
    input  logic signed [DW-1:0] x_l,
    input  logic signed [DW-1:0] x_r,
    input  logic signed [DW-1:0] t,
    input  logic [GW-1:0]        gain_l,
    input  logic [GW-1:0]        gain_r,
    input  logic [GW-1:0]        master,
    output logic signed [DW-1:0] res_c
);

    logic signed [DW-1:0]   a;
    logic [GW-1:0]          g;
    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   shifted;
    logic [PW-DW:0]         hi;

    // Pick the sample and gain for the current FSM step; the master pass is the default.
    always_comb begin
        a = t;
        g = master;
        unique case (state)
            ML1:     begin a = x_l; g = gain_l; end
            MR1:     begin a = x_r; g = gain_r; end
            default: ;
        endcase
    end

    // Signed sample times non-negative gain, floor-shift, clamp to the sample range.
    always_comb begin
        prod    = PW'(a) * PW'($signed({1'b0, g}));
        shifted = prod >>> FRAC;
        hi      = shifted[PW-1:DW-1];
        if ((hi == '0) || (hi == '1)) begin
            res_c = shifted[DW-1:0];
        end else if (shifted[PW-1]) begin
            res_c = {1'b1, {(DW-1){1'b0}}};
        end else begin
            res_c = {1'b0, {(DW-1){1'b1}}};
        end
    end

endmodule

// File: rtl/eq_gain_stage.sv
// EQ gain stage: coefficient CDC, deferred coefficient load, time-shared gain FSM.
module eq_gain_stage
    import eq_pkg::*;
(
    input  logic          clk,
    input  logic          realReset,
    input  logic [31:0]   eq_vals,
    input  logic          eq_done,
    input  logic          in_valid,
    input  logic [DW-1:0] in_l,
    input  logic [DW-1:0] in_r,
    output logic          out_valid,
    output logic [DW-1:0] out_l,
    output logic [DW-1:0] out_r,
    output logic          busy,
    output logic          overrun
);

    logic                 done_meta;
    logic                 done_sync;
    logic                 done_prev;
    logic                 done_rise_c;
    logic                 load_coef_c;
    logic                 pending;
    eq_coef_t             shadow;
    eq_coef_t             active;
    state_t               state_q;
    state_t               state_d;
    logic signed [DW-1:0] x_l;
    logic signed [DW-1:0] x_r;
    logic signed [DW-1:0] t_q;
    logic signed [DW-1:0] y_l;
    logic signed [DW-1:0] mul_c;
    logic                 unused_ctrl;

    assign done_rise_c = done_sync & ~done_prev;
    assign load_coef_c = pending & (state_q == IDLE) & ~in_valid;
    assign unused_ctrl = ^active.ctrl[GW-1:2];

    // Two-flop synchroniser on the SPI done flag plus an edge-history flop.
    always_ff @(posedge clk or posedge realReset) begin
        if (realReset) begin
            done_meta <= 1'b0;
            done_sync <= 1'b0;
            done_prev <= 1'b0;
        end else begin
            done_meta <= eq_done;
            done_sync <= done_meta;
            done_prev <= done_sync;
        end
    end

    // Shadow captures each new word; active only updates between samples.
    always_ff @(posedge clk or posedge realReset) begin
        if (realReset) begin
            shadow  <= COEF_RESET;
            active  <= COEF_RESET;
            pending <= 1'b0;
        end else begin
            if (load_coef_c) begin
                active  <= shadow;
                pending <= 1'b0;
            end
            if (done_rise_c) begin
                shadow  <= eq_coef_t'(eq_vals);
                pending <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge realReset) begin
        if (realReset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: fixed five-step sequence once a sample is accepted.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = ML1;
            ML1:     state_d = ML2;
            ML2:     state_d = MR1;
            MR1:     state_d = MR2;
            MR2:     state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    eq_sat_mul u_mul (
        .state  (state_q),
        .x_l    (x_l),
        .x_r    (x_r),
        .t      (t_q),
        .gain_l (active.gain_l),
        .gain_r (active.gain_r),
        .master (active.master),
        .res_c  (mul_c)
    );

    // Datapath and registered outputs; results land as the FSM enters OUT.
    always_ff @(posedge clk or posedge realReset) begin
        if (realReset) begin
            x_l       <= '0;
            x_r       <= '0;
            t_q       <= '0;
            y_l       <= '0;
            out_l     <= '0;
            out_r     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            busy      <= (state_d != IDLE);
            if (in_valid && (state_q != IDLE)) begin
                overrun <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        x_l <= in_l;
                        x_r <= in_r;
                    end
                end
                ML1, MR1: t_q <= mul_c;
                ML2:      y_l <= mul_c;
                MR2: begin
                    out_valid <= 1'b1;
                    if (active.ctrl[CTRL_MUTE]) begin
                        out_l <= '0;
                        out_r <= '0;
                    end else if (active.ctrl[CTRL_BYPASS]) begin
                        out_l <= x_l;
                        out_r <= x_r;
                    end else begin
                        out_l <= y_l;
                        out_r <= mul_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_eq_gain_stage.sv
// Bench for eq_gain_stage: cycle model of sample timing and coefficient hand-off.
module tb_eq_gain_stage;

    logic        clk = 1'b0;
    logic        realReset;
    logic [31:0] eq_vals;
    logic        eq_done;
    logic        in_valid;
    logic [15:0] in_l;
    logic [15:0] in_r;
    logic        out_valid;
    logic [15:0] out_l;
    logic [15:0] out_r;
    logic        busy;
    logic        overrun;

    always #5 clk = ~clk;

    eq_gain_stage dut (
        .clk       (clk),
        .realReset (realReset),
        .eq_vals   (eq_vals),
        .eq_done   (eq_done),
        .in_valid  (in_valid),
        .in_l      (in_l),
        .in_r      (in_r),
        .out_valid (out_valid),
        .out_l     (out_l),
        .out_r     (out_r),
        .busy      (busy),
        .overrun   (overrun)
    );

    typedef struct {
        int          due;
        logic [15:0] l;
        logic [15:0] r;
    } exp_t;

    typedef struct {
        int          at;
        logic [31:0] w;
    } arr_t;

    exp_t        out_q[$];
    arr_t        arr_q[$];
    int          cyc;
    int          m_cnt;
    logic        m_pend;
    logic        m_ovr;
    logic [31:0] m_shadow;
    logic [31:0] m_active;
    logic        prev_done;

    logic        exp_valid;
    logic        exp_busy;
    logic        exp_ovr;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
    logic        chk_en;
    int          n_vec;
    int          n_bad;

    // Q1.7 gain with floor rounding and clamping to 16-bit signed.
    function automatic logic [15:0] mul_sat(input logic [15:0] x, input logic [7:0] g);
        longint p;
        p = longint'($signed(x)) * longint'(g);
        p = p >>> 7;
        if (p > 32767) p = 32767;
        else if (p < -32768) p = -32768;
        return 16'(p);
    endfunction

    function automatic logic [15:0] chan_out(input logic [15:0] x, input logic [7:0] g,
                                             input logic [7:0] m, input logic [7:0] ctrl);
        if (ctrl[0]) return 16'h0000;
        if (ctrl[1]) return x;
        return mul_sat(mul_sat(x, g), m);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        out_q.delete();
        arr_q.delete();
        m_cnt     = 0;
        m_pend    = 1'b0;
        m_ovr     = 1'b0;
        m_shadow  = 32'h80808000;
        m_active  = 32'h80808000;
        prev_done = 1'b0;
        exp_valid = 1'b0;
        exp_busy  = 1'b0;
        exp_ovr   = 1'b0;
        exp_l     = 16'h0000;
        exp_r     = 16'h0000;
    endtask

    // Advance one clock: set this cycle's expectations, apply the inputs to the model.
    task automatic step();
        exp_t e;
        arr_t a;
        if (arr_q.size() > 0 && arr_q[0].at == cyc) begin
            m_pend   = 1'b1;
            m_shadow = arr_q[0].w;
            void'(arr_q.pop_front());
        end
        exp_busy  = (m_cnt != 0);
        exp_ovr   = m_ovr;
        exp_valid = 1'b0;
        if (out_q.size() > 0 && out_q[0].due == cyc) begin
            exp_valid = 1'b1;
            exp_l     = out_q[0].l;
            exp_r     = out_q[0].r;
            void'(out_q.pop_front());
        end
        if (eq_done && !prev_done) begin
            a.at = cyc + 3;
            a.w  = eq_vals;
            arr_q.push_back(a);
        end
        prev_done = eq_done;
        if (m_cnt == 0) begin
            if (in_valid) begin
                e.due = cyc + 5;
                e.l   = chan_out(in_l, m_active[31:24], m_active[15:8], m_active[7:0]);
                e.r   = chan_out(in_r, m_active[23:16], m_active[15:8], m_active[7:0]);
                out_q.push_back(e);
                m_cnt = 5;
            end else if (m_pend) begin
                m_active = m_shadow;
                m_pend   = 1'b0;
            end
        end else begin
            if (in_valid) m_ovr = 1'b1;
            m_cnt--;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic load(input logic [31:0] w);
        eq_vals = w;
        eq_done = 1'b1;
        repeat (2) step();
        eq_done = 1'b0;
        repeat (3) step();
    endtask

    task automatic sample(input logic [15:0] l, input logic [15:0] r,
                          output logic v, output logic [15:0] gl, output logic [15:0] gr);
        in_l     = l;
        in_r     = r;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        v  = out_valid;
        gl = out_l;
        gr = out_r;
        step();
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", 32'(out_valid), 32'(exp_valid));
            chk("busy",      32'(busy),      32'(exp_busy));
            chk("overrun",   32'(overrun),   32'(exp_ovr));
            chk("out_l",     32'(out_l),     32'(exp_l));
            chk("out_r",     32'(out_r),     32'(exp_r));
        end
    end

    initial begin
        logic        v;
        logic [15:0] gl;
        logic [15:0] gr;
        int          nv;
        int          gap;
        logic [31:0] w;
        int          c2;

        n_vec     = 0;
        n_bad     = 0;
        cyc       = 0;
        chk_en    = 1'b0;
        realReset = 1'b1;
        in_valid  = 1'b0;
        in_l      = '0;
        in_r      = '0;
        eq_vals   = '0;
        eq_done   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        realReset = 1'b0;

        chk("rst_out_l", 32'(out_l), 32'h0);
        chk("rst_out_r", 32'(out_r), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        chk("pin_sat_hi", 32'(mul_sat(16'h7000, 8'hFF)), 32'h7FFF);
        chk("pin_sat_lo", 32'(mul_sat(16'h8000, 8'hFF)), 32'h8000);
        chk("pin_floor", 32'(mul_sat(16'hFFFF, 8'h40)), 32'hFFFF);
        chk("pin_half", 32'(mul_sat(16'h1000, 8'h40)), 32'h0800);
        chk_en = 1'b1;

        sample(16'h1234, 16'hEDCC, v, gl, gr);
        chk("unity_valid", 32'(v), 32'h1);
        chk("unity_l", 32'(gl), 32'h1234);
        chk("unity_r", 32'(gr), 32'hEDCC);

        load(32'h40808000);
        sample(16'h1000, 16'h1000, v, gl, gr);
        chk("half_l", 32'(gl), 32'h0800);
        chk("half_r", 32'(gr), 32'h1000);

        load(32'hFFFF8000);
        sample(16'h7000, 16'h8000, v, gl, gr);
        chk("sat_l", 32'(gl), 32'h7FFF);
        chk("sat_r", 32'(gr), 32'h8000);

        load(32'h40808000);
        sample(16'hFFFF, 16'h0000, v, gl, gr);
        chk("floor_l", 32'(gl), 32'hFFFF);

        in_l = 16'h1000; in_r = 16'h1000; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        eq_vals = 32'h00808000; eq_done = 1'b1;
        repeat (2) step();
        eq_done = 1'b0;
        repeat (2) step();
        chk("defer_valid", 32'(out_valid), 32'h1);
        chk("defer_old_l", 32'(out_l), 32'h0800);
        repeat (2) step();
        sample(16'h1000, 16'h1000, v, gl, gr);
        chk("defer_new_l", 32'(gl), 32'h0000);
        chk("defer_new_r", 32'(gr), 32'h1000);

        load(32'h80808000);
        in_l = 16'h0100; in_r = 16'h0200; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        in_l = 16'h5555; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        nv = 0;
        repeat (8) begin
            if (out_valid) nv++;
            step();
        end
        chk("ovr_count", 32'(nv), 32'h1);
        chk("ovr_flag", 32'(overrun), 32'h1);
        chk("ovr_out_l", 32'(out_l), 32'h0100);
        repeat (3) step();
        chk("ovr_sticky", 32'(overrun), 32'h1);

        load(32'h80808003);
        sample(16'h1234, 16'h4321, v, gl, gr);
        chk("mute_l", 32'(gl), 32'h0);
        chk("mute_r", 32'(gr), 32'h0);

        load(32'h40408002);
        sample(16'h7000, 16'h8000, v, gl, gr);
        chk("bypass_l", 32'(gl), 32'h7000);
        chk("bypass_r", 32'(gr), 32'h8000);

        load(32'h40408000);
        in_l = 16'h1234; in_r = 16'h1234; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (2) step();
        chk("pre_rst_busy", 32'(busy), 32'h1);
        realReset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        realReset = 1'b0;
        nv = 0;
        repeat (6) begin
            if (out_valid) nv++;
            step();
        end
        chk("rst_no_valid", 32'(nv), 32'h0);
        chk("rst_mid_out_l", 32'(out_l), 32'h0);
        chk("rst_mid_ovr", 32'(overrun), 32'h0);
        sample(16'h1234, 16'h1234, v, gl, gr);
        chk("post_rst_l", 32'(gl), 32'h1234);
        chk("post_rst_r", 32'(gr), 32'h1234);

        gap = 0;
        repeat (3000) begin
            in_valid = ($urandom_range(0, 3) == 0);
            in_l     = 16'($urandom);
            in_r     = 16'($urandom);
            if (eq_done) begin
                eq_done = 1'b0;
                gap     = 4;
            end else if (gap > 0) begin
                gap--;
            end else if ($urandom_range(0, 19) == 0) begin
                w  = $urandom;
                c2 = $urandom_range(0, 7);
                w[1:0] = (c2 == 0) ? 2'b01 : (c2 == 1) ? 2'b10 : (c2 == 2) ? 2'b11 : 2'b00;
                eq_vals = w;
                eq_done = 1'b1;
            end
            step();
        end
        in_valid = 1'b0;
        eq_done  = 1'b0;
        repeat (8) step();
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
